// File: rtl/cordic_host_link.sv
// Host-side master for the byte-serial CORDIC vectoring link: sends (x, y) as
// four bytes, collects the six-byte (magnitude, phase) reply, aborts on stall.
module cordic_host_link #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TO_W           = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_x,
    input  logic [15:0] req_y,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_mag,
    output logic [31:0] rsp_phase,
    output logic        rsp_timeout,
    output logic [7:0]  link_tx_data,
    output logic        link_tx_valid,
    input  logic        link_tx_ready,
    input  logic [7:0]  link_rx_data,
    input  logic        link_rx_valid,
    output logic        link_rx_ready,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SEND, RECV, RESP} state_t;

    state_t          state, state_nxt;
    logic [2:0]      cnt;
    logic [TO_W-1:0] stall;
    logic [15:0]     x_q, y_q, mag_q;
    logic [31:0]     phase_q;
    logic            to_q;

    logic tx_fire, rx_fire, link_fire, stall_hit;

    // Readies are pure state decodes, so a transfer is known from state + peer valid/ready.
    assign tx_fire   = (state == SEND) && link_tx_ready;
    assign rx_fire   = (state == RECV) && link_rx_valid;
    assign link_fire = tx_fire || rx_fire;
    assign stall_hit = (stall == TO_W'(TIMEOUT_CYCLES - 1));

    // NOTE: sequential state uses non-blocking assignments and an asynchronous
    // active-low reset so every flop updates together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid) state_nxt = SEND;
            SEND: begin
                if (tx_fire) begin
                    if (cnt == 3'd3) state_nxt = RECV;
                end else if (stall_hit) begin
                    state_nxt = RESP;
                end
            end
            RECV: begin
                if (rx_fire) begin
                    if (cnt == 3'd5) state_nxt = RESP;
                end else if (stall_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            stall   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            mag_q   <= '0;
            phase_q <= '0;
            to_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        x_q     <= req_x;
                        y_q     <= req_y;
                        mag_q   <= '0;
                        phase_q <= '0;
                        to_q    <= 1'b0;
                        cnt     <= '0;
                        stall   <= '0;
                    end
                end
                SEND, RECV: begin
                    if (link_fire) begin
                        // A transfer on the terminal stall count still wins.
                        stall <= '0;
                        if (state_nxt != state) cnt <= '0;
                        else                    cnt <= cnt + 3'd1;
                    end else if (stall_hit) begin
                        to_q    <= 1'b1;
                        mag_q   <= '0;
                        phase_q <= '0;
                        stall   <= '0;
                        cnt     <= '0;
                    end else begin
                        stall <= stall + TO_W'(1);
                    end
                end
                default: ;
            endcase

            if (rx_fire) begin
                case (cnt)
                    3'd0:    mag_q[7:0]     <= link_rx_data;
                    3'd1:    mag_q[15:8]    <= link_rx_data;
                    3'd2:    phase_q[7:0]   <= link_rx_data;
                    3'd3:    phase_q[15:8]  <= link_rx_data;
                    3'd4:    phase_q[23:16] <= link_rx_data;
                    3'd5:    phase_q[31:24] <= link_rx_data;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        req_ready     = (state == IDLE);
        link_tx_valid = (state == SEND);
        link_rx_ready = (state == RECV);
        rsp_valid     = (state == RESP);
        busy          = (state != IDLE);
        rsp_mag       = mag_q;
        rsp_phase     = phase_q;
        rsp_timeout   = to_q;
        link_tx_data  = 8'h00;
        if (state == SEND) begin
            case (cnt[1:0])
                2'd0: link_tx_data = x_q[7:0];
                2'd1: link_tx_data = x_q[15:8];
                2'd2: link_tx_data = y_q[7:0];
                2'd3: link_tx_data = y_q[15:8];
            endcase
        end
    end

endmodule
